ecc_89_selftest_sched: RTL

//  Owns the input of one 89-bit SECDED checker/fault-detect slice on a FIFO read path and shares it

---
 rtl/ecc_89_selftest_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ecc_89_selftest_sched.sv
// Built-in self-test scheduler for one SECDED checker slice: muxes functional reads and a golden-codeword
// sweep (clean, every single-bit flip, one double flip) onto the checker and grades its responses.
module ecc_89_selftest_sched #(
  parameter int                      DATA_WIDTH   = 89,
  parameter int                      PARITY_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]   GOLD_DATA    = '0,
  parameter logic [PARITY_WIDTH-1:0] GOLD_PARITY  = '0,
  parameter int                      PERIOD       = 4096,
  parameter int                      CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    func_vld,
  output logic                    func_rdy,
  input  logic [DATA_WIDTH-1:0]   func_data,
  input  logic [PARITY_WIDTH-1:0] func_parity,
  input  logic                    cfg_bypass,
  input  logic                    cfg_detc_en,
  input  logic                    sw_start,
  input  logic                    test_abort,
  input  logic                    clr_stat,
  output logic [DATA_WIDTH-1:0]   chk_data,
  output logic [PARITY_WIDTH-1:0] chk_parity,
  output logic                    chk_bypass,
  output logic                    chk_detc_en,
  input  logic                    chk_sbit_err,
  input  logic                    chk_dbit_err,
  input  logic                    chk_fault,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail_sticky,
  output logic [6:0]              fail_step,
  output logic [CNT_W-1:0]        sbit_cnt,
  output logic [CNT_W-1:0]        dbit_cnt,
  output logic [CNT_W-1:0]        fault_cnt
);

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
  localparam logic [6:0] IDX_LAST  = 7'(DATA_WIDTH - 1);
  localparam logic [6:0] STEP_DBIT = 7'(DATA_WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAN, S_SBIT, S_DBIT, S_DONE} state_t;

  state_t          state, state_next;
  logic [6:0]      idx, idx_next;
  logic [TW-1:0]   timer;
  logic            pending;
  logic            run_err;
  logic            start;
  logic            checking;
  logic            mismatch;
  logic            func_acc;
  logic [2:0]      exp_resp;
  logic [6:0]      step_code;

  assign start    = (state == S_IDLE) & (sw_start | pending) & ~func_vld;
  assign checking = (state == S_CLEAN) | (state == S_SBIT) | (state == S_DBIT);
  assign func_rdy = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE) & ~test_abort;
  assign func_acc = func_vld & func_rdy;
  assign mismatch = checking & ({chk_sbit_err, chk_dbit_err, chk_fault} != exp_resp);

  // Checker input mux plus the expected response and step code for the current test step.
  always_comb begin
    chk_data    = func_data;
    chk_parity  = func_parity;
    chk_bypass  = cfg_bypass;
    chk_detc_en = cfg_detc_en;
    exp_resp    = 3'b000;
    step_code   = 7'd0;
    if (state != S_IDLE) begin
      chk_data    = GOLD_DATA;
      chk_parity  = GOLD_PARITY;
      chk_bypass  = 1'b0;
      chk_detc_en = 1'b1;
      case (state)
        S_SBIT: begin
          chk_data  = GOLD_DATA ^ (DATA_WIDTH'(1) << idx);
          exp_resp  = 3'b100;
          step_code = idx + 7'd1;
        end
        S_DBIT: begin
          chk_data  = GOLD_DATA ^ DATA_WIDTH'(3);
          exp_resp  = 3'b010;
          step_code = STEP_DBIT;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      S_IDLE: if (start) begin
        state_next = S_CLEAN;
        idx_next   = 7'd0;
      end
      S_CLEAN: state_next = test_abort ? S_IDLE : S_SBIT;
      S_SBIT: begin
        if (test_abort) state_next = S_IDLE;
        else if (idx == IDX_LAST) state_next = S_DBIT;
        else idx_next = idx + 7'd1;
      end
      S_DBIT:  state_next = test_abort ? S_IDLE : S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= 7'd0;
      timer       <= '0;
      pending     <= 1'b0;
      run_err     <= 1'b0;
      pass        <= 1'b0;
      fail_sticky <= 1'b0;
      fail_step   <= 7'd0;
      sbit_cnt    <= '0;
      dbit_cnt    <= '0;
      fault_cnt   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;

      if (start) begin
        timer   <= '0;
        pending <= 1'b0;
      end else if (PERIOD != 0 && state == S_IDLE) begin
        if (timer == TIMER_LAST) begin
          timer   <= '0;
          pending <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
      end

      if (start) run_err <= 1'b0;
      else if (mismatch) run_err <= 1'b1;

      if (state == S_DONE && !test_abort) pass <= ~run_err;

      // run_err still holds the run's history, so only the first mismatch lands in fail_step.
      if (clr_stat) begin
        fail_sticky <= 1'b0;
        fail_step   <= 7'd0;
      end else if (mismatch) begin
        fail_sticky <= 1'b1;
        if (!run_err) fail_step <= step_code;
      end

      if (clr_stat) begin
        sbit_cnt  <= '0;
        dbit_cnt  <= '0;
        fault_cnt <= '0;
      end else if (func_acc) begin
        if (chk_sbit_err && sbit_cnt  != '1) sbit_cnt  <= sbit_cnt  + CNT_W'(1);
        if (chk_dbit_err && dbit_cnt  != '1) dbit_cnt  <= dbit_cnt  + CNT_W'(1);
        if (chk_fault    && fault_cnt != '1) fault_cnt <= fault_cnt + CNT_W'(1);
      end
    end
  end

endmodule
